// File: rtl/arb_pkg.sv
// Shared constants, state encoding and channel-to-bit helper for the 8-channel
// round-robin arbiter. Channel 0 maps to bit 7 (MSB-first, encoder code order).
package arb_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, GRANT} state_e;

  function automatic logic [N-1:0] ch2bit(input logic [IDX_W-1:0] idx);
    return 8'b1000_0000 >> idx;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set candidate channel at or after ptr,
// wrapping 7 -> 0, returned as one-hot plus channel index.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any_o
);

  logic [IDX_W-1:0] w_ch;
  logic [IDX_W-1:0] w_bit;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any_o  = 1'b0;
    w_ch   = '0;
    w_bit  = '0;
    for (int k = 0; k < N; k++) begin
      w_ch  = ptr + IDX_W'(k);
      // channel c lives at bit 7-c, which for a 3-bit index is simply ~c
      w_bit = ~w_ch;
      if (!any_o && cand[w_bit]) begin
        any_o  = 1'b1;
        idx    = w_ch;
        onehot = ch2bit(w_ch);
      end
    end
  end

endmodule

// File: rtl/req_rr_arbiter_8.sv
// Round-robin request arbiter feeding the 8-to-3 encoder: sticky pending bits,
// registered strictly one-hot grant with valid/ready handshake.
module req_rr_arbiter_8
  import arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o,
  output logic         grant_valid_o,
  input  logic         grant_ready_i,
  output logic [N-1:0] pending_o
);

  state_e           r_state, w_state_nxt;
  logic [N-1:0]     r_grant, w_grant_nxt;
  logic [IDX_W-1:0] r_gidx, w_gidx_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [N-1:0]     r_pend;

  logic             w_accept;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_cand;
  logic [IDX_W-1:0] w_pick_ptr;
  logic [N-1:0]     w_pick_oh;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;

  assign w_accept = (r_state == GRANT) && grant_ready_i;
  assign w_clr    = w_accept ? r_grant : '0;
  assign w_cand   = r_pend & ~w_clr;
  // on an accept the search already starts from the advanced pointer
  assign w_pick_ptr = w_accept ? r_gidx + 3'd1 : r_ptr;

  rr_pick u_pick (
    .cand   (w_cand),
    .ptr    (w_pick_ptr),
    .onehot (w_pick_oh),
    .idx    (w_pick_idx),
    .any_o  (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick_oh;
          w_gidx_nxt  = w_pick_idx;
        end
      end
      GRANT: begin
        if (w_accept) begin
          w_ptr_nxt = r_gidx + 3'd1;
          if (w_pick_any) begin
            w_grant_nxt = w_pick_oh;
            w_gidx_nxt  = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_pend  <= (r_pend & ~w_clr) | req_i;
    end
  end

  assign grant_o       = r_grant;
  assign grant_valid_o = (r_state == GRANT);
  assign pending_o     = r_pend;

endmodule

// File: tb/tb_req_rr_arbiter_8.sv
// Bench for req_rr_arbiter_8: directed scenarios plus random traffic against a
// per-channel behavioural model.
module tb_req_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_i = '0;
  logic [7:0] grant_o;
  logic       grant_valid_o;
  logic       grant_ready_i = 1'b0;
  logic [7:0] pending_o;

  int n_tot = 0;
  int n_bad = 0;

  // model: per-channel pending flags, channel of outstanding grant, pointer
  bit m_pend[8];
  bit m_valid;
  int m_g;
  int m_ptr;

  req_rr_arbiter_8 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o),
    .grant_ready_i (grant_ready_i),
    .pending_o     (pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ch_vec(input int c);
    logic [7:0] v;
    v = '0;
    v[7-c] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) if (m_pend[c]) v |= ch_vec(c);
    return v;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 8; c++) m_pend[c] = 0;
    m_valid = 0;
    m_g = 0;
    m_ptr = 0;
  endtask

  // one clock of the model, given the inputs presented for that edge
  task automatic m_step(input logic [7:0] req, input bit rdy);
    bit cand[8];
    bit acc;
    bit found;
    acc = m_valid && rdy;
    for (int c = 0; c < 8; c++) cand[c] = m_pend[c];
    if (acc) begin
      cand[m_g] = 0;
      m_ptr = (m_g + 1) % 8;
    end
    if (!m_valid || acc) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && cand[(m_ptr + k) % 8]) begin
          found = 1;
          m_g = (m_ptr + k) % 8;
        end
      end
      m_valid = found;
    end
    for (int c = 0; c < 8; c++) m_pend[c] = cand[c] | req[7-c];
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".vld"},  {31'd0, grant_valid_o}, {31'd0, m_valid});
    chk({tag, ".gnt"},  {24'd0, grant_o}, m_valid ? {24'd0, ch_vec(m_g)} : 32'd0);
    chk({tag, ".pend"}, {24'd0, pending_o}, {24'd0, m_pend_vec()});
  endtask

  task automatic cyc(input logic [7:0] req, input bit rdy, input string tag);
    req_i = req;
    grant_ready_i = rdy;
    m_step(req, rdy);
    @(negedge clk);
    chk_model(tag);
  endtask

  task automatic do_reset();
    req_i = '0;
    grant_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk_model("rst");
  endtask

  localparam logic [7:0] FAIR [10] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                                       8'h04, 8'h02, 8'h01, 8'h80, 8'h40};

  initial begin
    m_reset();
    @(negedge clk);
    chk("reset.gnt", {24'd0, grant_o}, 32'd0);
    chk("reset.vld", {31'd0, grant_valid_o}, 32'd0);
    chk("reset.pend", {24'd0, pending_o}, 32'd0);
    rst_n = 1'b1;

    // back-to-back with wrap, then pointer back at channel 0
    cyc(8'h81, 1, "b2b");
    chk("b2b.pend", {24'd0, pending_o}, 32'h81);
    cyc(8'h00, 1, "b2b");
    chk("b2b.g0", {24'd0, grant_o}, 32'h80);
    cyc(8'h00, 1, "b2b");
    chk("b2b.g1", {24'd0, grant_o}, 32'h01);
    cyc(8'h00, 1, "b2b");
    chk("b2b.idle", {31'd0, grant_valid_o}, 32'd0);
    cyc(8'h81, 1, "b2b2");
    cyc(8'h00, 1, "b2b2");
    chk("b2b.ptr0", {24'd0, grant_o}, 32'h80);
    cyc(8'h00, 1, "b2b2");
    cyc(8'h00, 1, "b2b2");

    // single request
    do_reset();
    cyc(8'h80, 1, "single");
    chk("single.pend", {24'd0, pending_o}, 32'h80);
    chk("single.novld", {31'd0, grant_valid_o}, 32'd0);
    cyc(8'h00, 1, "single");
    chk("single.gnt", {24'd0, grant_o}, 32'h80);
    chk("single.vld", {31'd0, grant_valid_o}, 32'd1);
    cyc(8'h00, 1, "single");
    chk("single.end", {23'd0, grant_valid_o, pending_o}, 32'd0);

    // fairness under full load
    do_reset();
    cyc(8'hFF, 1, "fair");
    for (int i = 0; i < 10; i++) begin
      cyc(8'hFF, 1, "fair");
      chk($sformatf("fair%0d", i), {24'd0, grant_o}, {24'd0, FAIR[i]});
    end
    for (int i = 0; i < 10; i++) cyc(8'h00, 1, "drain");

    // stall: ch2 outstanding while ch0 arrives
    do_reset();
    cyc(8'h20, 0, "stall");
    cyc(8'h00, 0, "stall");
    for (int i = 0; i < 5; i++) begin
      cyc(8'h80, 0, "stall");
      chk("stall.hold", {23'd0, grant_valid_o, grant_o}, 32'h120);
    end
    cyc(8'h00, 1, "stall");
    chk("stall.next", {24'd0, grant_o}, 32'h80);
    cyc(8'h00, 1, "stall");

    // re-request of the accepted channel in the accept cycle
    do_reset();
    cyc(8'h10, 0, "rereq");
    cyc(8'h00, 0, "rereq");
    cyc(8'h10, 1, "rereq");
    chk("rereq.pend4", {31'd0, pending_o[4]}, 32'd1);
    cyc(8'h00, 1, "rereq");
    chk("rereq.again", {23'd0, grant_valid_o, grant_o}, 32'h110);
    cyc(8'h00, 1, "rereq");

    // asynchronous reset mid-grant
    cyc(8'hF0, 0, "mrst");
    cyc(8'h00, 0, "mrst");
    chk("mrst.pre", {23'd0, grant_valid_o, pending_o}, 32'h1F0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.now", {15'd0, grant_valid_o, grant_o, pending_o}, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(8'h00, 1, "mrst.after");

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] r;
      bit rdy;
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      rdy = ($urandom_range(0, 3) != 0);
      if (i == 1000) do_reset();
      cyc(r, rdy, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
